// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one cache port among NUM_REQ requesters.
// Round-robin grant, one outstanding transaction, flush has priority,
// and a stall watchdog ends hung transactions with an error ack.
module cache_port_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int REQ_IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int addr_bus_width = 32,
   parameter int data_bus_width = 32,
   parameter int STALL_TIMEOUT  = 255
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_rd,
   input  logic [NUM_REQ-1:0]                req_wr,
   input  logic [NUM_REQ*addr_bus_width-1:0] req_addr,
   input  logic [NUM_REQ*data_bus_width-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                req_ack,
   output logic                              req_err,
   output logic [data_bus_width-1:0]         req_rdata,
   input  logic                              flush_req,
   output logic                              flush_ack,
   output logic [addr_bus_width-1:0]         cache_addr,
   output logic [data_bus_width-1:0]         cache_wdata,
   output logic                              cache_rd,
   output logic                              cache_wr,
   output logic                              cache_flush,
   input  logic [data_bus_width-1:0]         cache_rdata,
   input  logic                              cache_stall,
   output logic                              busy,
   output logic [REQ_IDX_W-1:0]              grant_idx
);

   localparam int AW = addr_bus_width;
   localparam int DW = data_bus_width;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      FLUSH,
      FLUSH_WAIT
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [REQ_IDX_W-1:0]   last_q;
   logic [REQ_IDX_W-1:0]   gidx_q;
   logic [AW-1:0]          addr_q;
   logic [DW-1:0]          wdata_q;
   logic                   wr_q;
   logic [7:0]             stall_cnt_q;
   logic [NUM_REQ-1:0]     ack_q;
   logic                   err_q;
   logic                   fack_q;
   logic [DW-1:0]          rdata_q;

   logic                   pick_vld;
   logic [REQ_IDX_W-1:0]   pick_idx;
   logic [REQ_IDX_W-1:0]   cand;
   logic                   pick_wr;
   logic [AW-1:0]          pick_addr;
   logic [DW-1:0]          pick_wdata;
   logic                   ack_cycle;
   logic                   timeout;
   logic                   start_req;

   // The cycle carrying an ack pulse is not arbitrated: the acked client
   // still shows its request then and must not be granted a second time.
   assign ack_cycle = (|ack_q) | fack_q;
   assign timeout   = cache_stall && (stall_cnt_q == 8'(STALL_TIMEOUT - 1));
   assign start_req = (state_q == IDLE) && !ack_cycle && !flush_req && pick_vld;

   // Round-robin pick: scan farthest to nearest from last_q so the nearest requester wins.
   always_comb begin
      pick_vld   = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      pick_wr    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = REQ_IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (req_rd[cand] || req_wr[cand]) begin
            pick_vld   = 1'b1;
            pick_idx   = cand;
            pick_wr    = req_wr[cand];
            pick_addr  = req_addr[int'(cand)*AW +: AW];
            pick_wdata = req_wdata[int'(cand)*DW +: DW];
         end
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!ack_cycle) begin
               if (flush_req) begin
                  state_d = FLUSH;
               end else if (pick_vld) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE:      state_d = WAIT;
         WAIT:       if (!cache_stall || timeout) state_d = IDLE;
         FLUSH:      state_d = FLUSH_WAIT;
         FLUSH_WAIT: if (!cache_stall || timeout) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Grant latch, stall watchdog, ack pulses and read-data capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q      <= REQ_IDX_W'(NUM_REQ - 1);
         gidx_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         stall_cnt_q <= '0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         fack_q      <= 1'b0;
         rdata_q     <= '0;
      end else begin
         ack_q  <= '0;
         err_q  <= 1'b0;
         fack_q <= 1'b0;
         if (start_req) begin
            last_q  <= pick_idx;
            gidx_q  <= pick_idx;
            addr_q  <= pick_addr;
            wdata_q <= pick_wdata;
            wr_q    <= pick_wr;
         end
         if (state_q == WAIT || state_q == FLUSH_WAIT) begin
            if (!cache_stall || timeout) begin
               stall_cnt_q <= '0;
               if (state_q == WAIT) begin
                  ack_q[gidx_q] <= 1'b1;
                  err_q         <= cache_stall;
                  if (!cache_stall && !wr_q) begin
                     rdata_q <= cache_rdata;
                  end
               end else begin
                  fack_q <= 1'b1;
               end
            end else begin
               stall_cnt_q <= stall_cnt_q + 8'd1;
            end
         end
      end
   end

   assign req_ack     = ack_q;
   assign req_err     = err_q;
   assign req_rdata   = rdata_q;
   assign flush_ack   = fack_q;
   assign cache_addr  = addr_q;
   assign cache_wdata = wdata_q;
   assign cache_rd    = (state_q == ISSUE) && !wr_q;
   assign cache_wr    = (state_q == ISSUE) && wr_q;
   assign cache_flush = (state_q == FLUSH);
   assign busy        = (state_q != IDLE);
   assign grant_idx   = gidx_q;

endmodule
